pattern_sequencer: RTL and testbench
====================================

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 The module SHALL have parameter DWELL_W, default 8, giving the width of the dwell-frame count.
REQ-002 The module SHALL have parameter PAT_FIRST, default 1, giving the first pattern index in the sequence.
REQ-003 The module SHALL have parameter PAT_LAST, default 12, giving the last pattern index in the sequence; PAT_FIRST <= PAT_LAST <= 15.
REQ-004 Port i_Clk  input  1  pixel clock; the only clock.
REQ-005 Port rst  input  1  reset, synchronous and active-high.
REQ-006 Port i_VSync  input  1  frame sync, same signal that drives the pattern generator.
REQ-007 Port i_Enable  input  1  1 = sequencer running, 0 = output pattern 0.
REQ-008 Port i_Auto  input  1  1 = auto-advance after dwell, 0 = manual advance only.
REQ-009 Port i_Next  input  1  advance request, level input; the rising edge is the event.
REQ-010 Port i_Dwell_Frames  input  DWELL_W  frames to show each pattern in auto mode.
REQ-011 Port o_Pattern  output  4  pattern select, drives the generator i_Pattern.
REQ-012 Port o_Frame_Tick  output  1  one-cycle pulse per detected frame start.
REQ-013 Port o_Advance  output  1  one-cycle pulse on each pattern change.

Function
REQ-014 frame_start SHALL be i_VSync sampled high while its registered copy is low; rising edge only.
REQ-015 next_evt SHALL be i_Next high while its registered copy is low.
REQ-016 States SHALL be OFF, SHOW and ARMED.
REQ-017 OFF: o_Pattern = 0; on frame_start with i_Enable = 1 go to SHOW, o_Pattern <= PAT_FIRST, dwell counter <= 0, o_Advance pulses.
REQ-018 SHOW: next_evt SHALL go to ARMED; on frame_start the dwell counter SHALL increment.
REQ-019 SHOW with i_Auto = 1: at the frame_start where counter+1 >= max(i_Dwell_Frames, 1), pattern SHALL advance and the counter SHALL clear; i_Dwell_Frames = 0 behaves as 1.
REQ-020 ARMED: at the next frame_start, pattern SHALL advance, the counter SHALL clear, and state SHALL return to SHOW; further next_evt while ARMED collapse into the one pending advance.
REQ-021 Advance SHALL be o_Pattern + 1; at PAT_LAST it SHALL wrap to PAT_FIRST; o_Advance pulses the same cycle o_Pattern changes.
REQ-022 o_Pattern SHALL change only on a frame_start cycle (registered, visible the following cycle), never mid-frame.
REQ-023 next_evt coincident with frame_start in SHOW SHALL arm and apply at the following frame_start, not the current one; an auto advance in that cycle still occurs.
REQ-024 i_Enable = 0 in any state SHALL force OFF and o_Pattern <= 0 on the next edge, clearing any pending advance and the counter.
REQ-025 i_Auto 1->0 SHALL clear the dwell counter; i_Auto 0->1 SHALL start counting from 0.
REQ-026 o_Frame_Tick SHALL be frame_start registered once (1-cycle latency).

Reset
REQ-027 rst SHALL override all other inputs, including i_Enable.
REQ-028 On rst: state OFF, o_Pattern = 0, o_Frame_Tick = 0, o_Advance = 0, counter = 0, edge registers = 0.
REQ-029 After rst deassertion, an i_VSync or i_Next already high SHALL register as an edge, since edge registers start at 0.
REQ-030 rst asserted mid-ARMED SHALL discard the pending advance.

Structure
REQ-031 Package pattern_seq_pkg SHALL hold the state encoding (OFF/SHOW/ARMED), PATTERN_W = 4, and default PAT_FIRST/PAT_LAST constants.
REQ-032 One sub-module, sync_edge_detect (1-bit register plus rising-edge pulse, synchronous reset), SHALL be instantiated twice: once for i_VSync, once for i_Next.

Verification
REQ-033 Enable with auto start: rst, i_Enable = 1, i_Auto = 1, i_Dwell_Frames = 2 -> first frame_start gives o_Pattern 1; thereafter o_Pattern 2, 3, ... every 2 frames; 12 -> 1 wrap with o_Advance pulse.
REQ-034 Manual advance: i_Auto = 0, 3 i_Next pulses mid-frame -> exactly one advance, 1 -> 2, at the next frame_start; nothing changes mid-frame.
REQ-035 Coincident events: i_Next rising in the frame_start cycle -> pattern advances one frame later, not this frame.
REQ-036 Zero dwell: i_Dwell_Frames = 0, auto -> advance every frame, identical to i_Dwell_Frames = 1.
REQ-037 Disable while armed: i_Enable = 0 while ARMED -> o_Pattern = 0 next cycle; re-enable -> pattern 1 at next frame_start, with no stale advance.
REQ-038 Reset mid-run: rst at o_Pattern = 7 -> all outputs 0 next edge; o_Frame_Tick pulses 1 cycle after each i_VSync rise.

Source files
------------

// File: rtl/pattern_seq_pkg.sv
// Shared types and constants for the test-pattern sequencer.
package pattern_seq_pkg;

  localparam int PATTERN_W     = 4;
  localparam int PAT_FIRST_DEF = 1;
  localparam int PAT_LAST_DEF  = 12;

  // OFF: output pattern 0; SHOW: displaying a pattern; ARMED: manual advance pending
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_SHOW  = 2'd1,
    ST_ARMED = 2'd2
  } seq_state_t;

  // Step to the following pattern, wrapping from the last index back to the first.
  function automatic logic [PATTERN_W-1:0] next_pattern(
    input logic [PATTERN_W-1:0] cur,
    input logic [PATTERN_W-1:0] first,
    input logic [PATTERN_W-1:0] last
  );
    return (cur == last) ? first : cur + 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// One-bit registered copy of a level input plus a rising-edge pulse.
// The pulse is combinational: high in the cycle the input is seen high
// while its registered copy is still low.
module sync_edge_detect (
  input  logic i_Clk,
  input  logic rst,
  input  logic i_Sig,
  output logic o_Rise
);

  logic sig_q;

  // Track the previous-cycle value of the input; cleared by reset so a
  // level already high after reset registers as an edge.
  always_ff @(posedge i_Clk) begin
    // NOTE: registers are written with non-blocking assignments so every
    // flop samples pre-edge values, regardless of block ordering.
    if (rst) sig_q <= 1'b0;
    else     sig_q <= i_Sig;
  end

  assign o_Rise = i_Sig & ~sig_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Steps a video pattern generator through a range of pattern indices,
// either automatically after a dwell of N frames or on a manual request.
// Pattern changes only ever take effect on a frame start, never mid-frame.
module pattern_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int DWELL_W   = 8,
  parameter int PAT_FIRST = PAT_FIRST_DEF,
  parameter int PAT_LAST  = PAT_LAST_DEF
) (
  input  logic                 i_Clk,
  input  logic                 rst,
  input  logic                 i_VSync,
  input  logic                 i_Enable,
  input  logic                 i_Auto,
  input  logic                 i_Next,
  input  logic [DWELL_W-1:0]   i_Dwell_Frames,
  output logic [PATTERN_W-1:0] o_Pattern,
  output logic                 o_Frame_Tick,
  output logic                 o_Advance
);

  localparam logic [PATTERN_W-1:0] FIRST_P = PATTERN_W'(PAT_FIRST);
  localparam logic [PATTERN_W-1:0] LAST_P  = PATTERN_W'(PAT_LAST);

  seq_state_t          state;
  logic [DWELL_W-1:0]  dwell_cnt;
  logic                frame_start;
  logic                next_evt;
  logic [DWELL_W:0]    cnt_inc;
  logic [DWELL_W:0]    dwell_eff;
  logic                dwell_done;
  logic [PATTERN_W-1:0] pat_next;

  sync_edge_detect u_vsync_edge (
    .i_Clk  (i_Clk),
    .rst    (rst),
    .i_Sig  (i_VSync),
    .o_Rise (frame_start)
  );

  sync_edge_detect u_next_edge (
    .i_Clk  (i_Clk),
    .rst    (rst),
    .i_Sig  (i_Next),
    .o_Rise (next_evt)
  );

  // One extra bit keeps counter+1 from wrapping before the compare;
  // a dwell of zero frames behaves as one.
  assign cnt_inc    = {1'b0, dwell_cnt} + 1'b1;
  assign dwell_eff  = (i_Dwell_Frames == '0) ? (DWELL_W+1)'(1) : {1'b0, i_Dwell_Frames};
  assign dwell_done = (cnt_inc >= dwell_eff);
  assign pat_next   = next_pattern(o_Pattern, FIRST_P, LAST_P);

  // Sequencer FSM with registered pattern, frame tick and advance pulse.
  // o_Advance marks sequence steps only (first pattern and each advance),
  // not the forced return to pattern 0 on disable.
  always_ff @(posedge i_Clk) begin
    if (rst) begin
      state        <= ST_OFF;
      o_Pattern    <= '0;
      o_Frame_Tick <= 1'b0;
      o_Advance    <= 1'b0;
      dwell_cnt    <= '0;
    end else begin
      o_Frame_Tick <= frame_start;
      o_Advance    <= 1'b0;
      if (!i_Enable) begin
        state     <= ST_OFF;
        o_Pattern <= '0;
        dwell_cnt <= '0;
      end else begin
        unique case (state)
          ST_OFF: begin
            if (frame_start) begin
              state     <= ST_SHOW;
              o_Pattern <= FIRST_P;
              dwell_cnt <= '0;
              o_Advance <= 1'b1;
            end
          end
          ST_SHOW: begin
            // Counting only runs in auto mode, so leaving auto clears it and
            // re-entering auto counts from zero.
            if (!i_Auto) begin
              dwell_cnt <= '0;
            end else if (frame_start) begin
              if (dwell_done) begin
                o_Pattern <= pat_next;
                o_Advance <= 1'b1;
                dwell_cnt <= '0;
              end else begin
                dwell_cnt <= cnt_inc[DWELL_W-1:0];
              end
            end
            // A request in a frame-start cycle arms for the following frame.
            if (next_evt) state <= ST_ARMED;
          end
          ST_ARMED: begin
            // Repeated requests while armed collapse into this one advance.
            if (frame_start) begin
              o_Pattern <= pat_next;
              o_Advance <= 1'b1;
              dwell_cnt <= '0;
              state     <= ST_SHOW;
            end else if (!i_Auto) begin
              dwell_cnt <= '0;
            end
          end
          default: begin
            state     <= ST_OFF;
            o_Pattern <= '0;
            dwell_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: directed scenarios followed by
// randomized traffic, every cycle compared with a behavioural model.
module tb_pattern_sequencer;

  localparam int FIRST = 1;
  localparam int LAST  = 12;
  localparam int NPAT  = LAST - FIRST + 1;

  logic       i_Clk = 1'b0;
  logic       rst, i_VSync, i_Enable, i_Auto, i_Next;
  logic [7:0] i_Dwell_Frames;
  logic [3:0] o_Pattern;
  logic       o_Frame_Tick, o_Advance;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state: what the outputs should be after the next edge.
  bit m_vs_prev, m_nx_prev, m_running, m_pending, m_tick, m_adv;
  int m_frames, m_pat;

  always #5 i_Clk = ~i_Clk;

  pattern_sequencer #(
    .DWELL_W   (8),
    .PAT_FIRST (FIRST),
    .PAT_LAST  (LAST)
  ) dut (
    .i_Clk          (i_Clk),
    .rst            (rst),
    .i_VSync        (i_VSync),
    .i_Enable       (i_Enable),
    .i_Auto         (i_Auto),
    .i_Next         (i_Next),
    .i_Dwell_Frames (i_Dwell_Frames),
    .o_Pattern      (o_Pattern),
    .o_Frame_Tick   (o_Frame_Tick),
    .o_Advance      (o_Advance)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int nxt(input int p);
    return FIRST + ((p - FIRST + 1) % NPAT);
  endfunction

  // Apply the sequencing rules to the inputs currently driven.
  task automatic model_step();
    bit fs, ne, step;
    int need;
    fs = i_VSync && !m_vs_prev;
    ne = i_Next && !m_nx_prev;
    if (rst) begin
      m_vs_prev = 0; m_nx_prev = 0; m_running = 0; m_pending = 0;
      m_tick = 0; m_adv = 0; m_frames = 0; m_pat = 0;
      return;
    end
    m_vs_prev = i_VSync;
    m_nx_prev = i_Next;
    m_tick    = fs;
    m_adv     = 0;
    if (!i_Enable) begin
      m_running = 0; m_pending = 0; m_frames = 0; m_pat = 0;
    end else if (!m_running) begin
      if (fs) begin
        m_running = 1; m_pat = FIRST; m_frames = 0; m_adv = 1;
      end
    end else begin
      step = 0;
      need = (i_Dwell_Frames == 0) ? 1 : int'(i_Dwell_Frames);
      if (!i_Auto) m_frames = 0;
      else if (fs) begin
        m_frames++;
        if (m_frames >= need) begin step = 1; m_frames = 0; end
      end
      if (m_pending) begin
        if (fs) begin step = 1; m_pending = 0; m_frames = 0; end
      end else if (ne) begin
        m_pending = 1;
      end
      if (step) begin m_pat = nxt(m_pat); m_adv = 1; end
    end
  endtask

  // One clock: update model from driven inputs, then compare after the edge.
  task automatic cyc();
    model_step();
    @(posedge i_Clk);
    #1;
    check("pattern", o_Pattern, m_pat);
    check("frame_tick", o_Frame_Tick, m_tick);
    check("advance", o_Advance, m_adv);
  endtask

  initial begin
    int p0, prev_pat;
    bit saw_wrap;

    // Reset held with VSync and Next already high.
    rst = 1; i_Enable = 0; i_Auto = 0; i_VSync = 1; i_Next = 1; i_Dwell_Frames = 8'd2;
    repeat (3) cyc();
    check("rst_pattern", o_Pattern, 0);
    check("rst_tick", o_Frame_Tick, 0);
    check("rst_adv", o_Advance, 0);

    // Auto run, dwell 2: levels high at release count as edges.
    rst = 0; i_Enable = 1; i_Auto = 1; i_Next = 0;
    cyc();
    check("first_pat", o_Pattern, FIRST);
    check("first_adv", o_Advance, 1);
    check("first_tick", o_Frame_Tick, 1);
    i_VSync = 0; repeat (2) cyc();
    saw_wrap = 0; prev_pat = FIRST;
    for (int k = 0; k < 28; k++) begin
      i_VSync = 1; cyc();
      if (o_Advance) begin
        if (prev_pat == LAST && o_Pattern == FIRST) saw_wrap = 1;
        prev_pat = int'(o_Pattern);
      end
      i_VSync = 0; repeat (2) cyc();
    end
    check("wrap_seen", saw_wrap, 1);

    // Manual: three requests mid-frame give exactly one advance.
    i_Auto = 0;
    i_VSync = 1; cyc(); i_VSync = 0; cyc();
    p0 = m_pat;
    repeat (3) begin
      i_Next = 1; cyc(); check("mid_hold", o_Pattern, p0);
      i_Next = 0; cyc(); check("mid_hold", o_Pattern, p0);
    end
    i_VSync = 1; cyc(); check("man_adv", o_Pattern, nxt(p0));
    i_VSync = 0; repeat (2) cyc();
    i_VSync = 1; cyc(); check("man_once", o_Pattern, nxt(p0));

    // Request coincident with frame start applies one frame later.
    i_VSync = 0; repeat (2) cyc();
    p0 = m_pat;
    i_VSync = 1; i_Next = 1; cyc(); check("coinc_hold", o_Pattern, p0);
    i_VSync = 0; i_Next = 0; repeat (2) cyc();
    i_VSync = 1; cyc(); check("coinc_apply", o_Pattern, nxt(p0));
    i_VSync = 0; cyc();

    // Dwell 0 and dwell 1 both advance every frame.
    i_Auto = 1;
    for (int d = 0; d < 2; d++) begin
      i_Dwell_Frames = 8'(d);
      repeat (4) begin
        i_VSync = 1; cyc(); check("dwell_adv", o_Advance, 1);
        i_VSync = 0; repeat (2) cyc();
      end
    end

    // Disable while armed: no stale advance after re-enable.
    i_Auto = 0;
    i_Next = 1; cyc(); i_Next = 0;
    i_Enable = 0; cyc(); check("dis_pat", o_Pattern, 0);
    i_Enable = 1; cyc(); check("dis_hold", o_Pattern, 0);
    i_VSync = 1; cyc(); check("reen_pat", o_Pattern, FIRST);
    i_VSync = 0; repeat (2) cyc();
    i_VSync = 1; cyc(); check("no_stale", o_Pattern, FIRST);
    i_VSync = 0; cyc();

    // Run to pattern 7 then reset mid-run.
    i_Auto = 1; i_Dwell_Frames = 8'd1;
    for (int k = 0; k < 40 && m_pat != 7; k++) begin
      i_VSync = 1; cyc(); i_VSync = 0; cyc();
    end
    check("reach7", o_Pattern, 7);
    rst = 1; cyc();
    check("mid_rst_pat", o_Pattern, 0);
    check("mid_rst_adv", o_Advance, 0);
    rst = 0; cyc();
    repeat (3) begin
      i_VSync = 1; cyc(); check("tick_pulse", o_Frame_Tick, 1);
      cyc(); check("tick_low", o_Frame_Tick, 0);
      i_VSync = 0; repeat (2) cyc();
    end

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      i_Enable = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 59) == 0) i_Auto = ~i_Auto;
      if ($urandom_range(0, 99) == 0) i_Dwell_Frames = 8'($urandom_range(0, 3));
      i_VSync  = ($urandom_range(0, 3) == 0);
      i_Next   = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
